regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every register and data port.
REQ-002 Parameter ADDR_WIDTH, default 5: register index width; NUM_REGS = 2**ADDR_WIDTH, derived and not overridable.
REQ-003 Parameter OBS_REG, default 25: index of the register driven onto output_register; legal range 0..NUM_REGS-1.
REQ-004 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port ctrl_reset, input, 1: reset, synchronous and active-low (0 = reset).
REQ-006 Port ctrl_writeEnable, input, 1: write strobe.
REQ-007 Port ctrl_writeReg, input, ADDR_WIDTH: write index.
REQ-008 Port data_writeReg, input, DATA_WIDTH: write data.
REQ-009 Port ctrl_readRegA, input, ADDR_WIDTH, and port ctrl_readRegB, input, ADDR_WIDTH: read indices.
REQ-010 Port data_readRegA, output, DATA_WIDTH, and port data_readRegB, output, DATA_WIDTH: read data.
REQ-011 Port ctrl_markPending, input, 1: issue strobe; marks ctrl_pendingReg as awaiting writeback.
REQ-012 Port ctrl_pendingReg, input, ADDR_WIDTH: index to mark pending.
REQ-013 Port busy_A, output, 1, and port busy_B, output, 1: the selected read register is pending.
REQ-014 Port pending_count, output, ADDR_WIDTH+1: number of registers currently pending.
REQ-015 Port output_register, output, DATA_WIDTH: contents of register OBS_REG.

Function
REQ-016 Reads: combinational; data_readRegX = register[ctrl_readRegX]; a register with no write since reset reads 0.
REQ-017 Write: on a rising edge with ctrl_reset=1 and ctrl_writeEnable=1, register[ctrl_writeReg] takes data_writeReg.
REQ-018 Register 0: always reads 0 and is never pending; writes to it and marks on it have no effect.
REQ-019 Scoreboard set: ctrl_markPending=1 with ctrl_pendingReg!=0 sets pending[ctrl_pendingReg] at the edge.
REQ-020 Scoreboard clear: a write with ctrl_writeReg!=0 clears pending[ctrl_writeReg] at the edge.
REQ-021 Mark and write to the same index in one cycle: the register is written and pending ends at 1 (the set wins).
REQ-022 Mark and write to different indices in one cycle: both actions apply independently.
REQ-023 busy_X = pending[ctrl_readRegX], except as modified by REQ-031; busy_X is always 0 when index 0 is selected.
REQ-024 pending_count equals the population count of pending after each edge; it changes only on a 0->1 or 1->0 transition of a pending bit.
REQ-025 pending_count: +1 on a mark-only of a non-pending register, -1 on a clear-only of a pending register, and unchanged for a simultaneous set and clear of different pending bits; it never wraps and its maximum is NUM_REGS-1.
REQ-026 A write to a non-pending register updates the data only; pending and pending_count are unchanged.
REQ-027 output_register: combinational view of register OBS_REG, with the same bypass rule as the read ports.

Reset
REQ-028 On a rising edge with ctrl_reset=0: all registers become 0, all pending bits become 0, and pending_count becomes 0.
REQ-029 During reset, reset overrides the write and mark strobes; those strobes are ignored for that edge.
REQ-030 Outputs after reset: data_readRegA, data_readRegB and output_register are 0; busy_A and busy_B are 0; pending_count is 0.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN defined: in a cycle where ctrl_writeEnable=1 and ctrl_writeReg equals a nonzero read index (or OBS_REG), that port outputs data_writeReg combinationally and its busy_X is forced to 0.
REQ-032 Macro REGFILE_BYPASS_EN undefined: no forwarding; in that cycle the read port returns the old contents, the new value is visible the cycle after the write edge, and busy_X follows the pending bit directly.

Verification
REQ-033 Reset, then write reg 5 = 0xDEADBEEF; read A=5, B=0 -> the cycle after the edge, A=0xDEADBEEF and B=0.
REQ-034 Write reg 0 = 0xFFFFFFFF and mark reg 0 -> data_readRegA(0)=0, busy_A=0, pending_count=0.
REQ-035 Mark reg 3, then mark reg 7 -> pending_count=2 and busy_A(3)=1; then write reg 3 -> pending_count=1 and busy_A(3)=0.
REQ-036 Mark reg 9 and write reg 9 = 0x12 in the same cycle, with reg 9 not previously pending -> reg 9=0x12, busy=1, pending_count=1.
REQ-037 Write reg 25 = 0xA5A5A5A5 with read A=25 in the same cycle -> with REGFILE_BYPASS_EN, A and output_register show 0xA5A5A5A5 in that cycle; without it, they show the old value until the next cycle.
REQ-038 With regs 1..4 pending, assert ctrl_reset=0 for one edge while writing reg 2 -> all registers are 0, pending_count=0, and reg 2 reads 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with two combinational read ports, one
// write port and a per-register pending (scoreboard) bit with a running count.
// Register 0 is hard-wired to zero and can never be pending.
//
// Optional feature, macro REGFILE_BYPASS_EN:
//   defined   - a same-cycle write to a selected nonzero read index (or to
//               OBS_REG) is forwarded to that port, and its busy flag reads 0.
//   undefined - no forwarding; reads show the stored contents and busy follows
//               the pending bit directly.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int OBS_REG    = 25
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  ctrl_markPending,
    input  logic [ADDR_WIDTH-1:0] ctrl_pendingReg,
    output logic                  busy_A,
    output logic                  busy_B,
    output logic [ADDR_WIDTH:0]   pending_count,
    output logic [DATA_WIDTH-1:0] output_register
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] OBS_IDX = ADDR_WIDTH'(OBS_REG);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_pending;
    logic [ADDR_WIDTH:0]   r_count;

    logic                  w_wr_valid;
    logic                  w_mark_valid;
    logic                  w_same_idx;
    logic                  w_rise;
    logic                  w_fall;
    logic [NUM_REGS-1:0]   w_pending_next;
    logic [ADDR_WIDTH:0]   w_count_next;

    logic [DATA_WIDTH-1:0] w_read_a;
    logic [DATA_WIDTH-1:0] w_read_b;
    logic [DATA_WIDTH-1:0] w_read_obs;
    logic                  w_busy_a;
    logic                  w_busy_b;

    // Qualify strobes (index 0 is inert) and derive next pending vector and count.
    always_comb begin
        w_wr_valid     = ctrl_writeEnable && (ctrl_writeReg != '0);
        w_mark_valid   = ctrl_markPending && (ctrl_pendingReg != '0);
        w_same_idx     = w_wr_valid && w_mark_valid && (ctrl_writeReg == ctrl_pendingReg);
        w_pending_next = r_pending;
        // Clear is applied first so a mark to the same index wins.
        if (w_wr_valid) begin
            w_pending_next[ctrl_writeReg] = 1'b0;
        end
        if (w_mark_valid) begin
            w_pending_next[ctrl_pendingReg] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
        // Only real bit transitions move the count.
        w_rise = w_mark_valid && !r_pending[ctrl_pendingReg];
        w_fall = w_wr_valid && r_pending[ctrl_writeReg] && !w_same_idx;
        unique case ({w_rise, w_fall})
            2'b10:   w_count_next = r_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
            2'b01:   w_count_next = r_count - {{ADDR_WIDTH{1'b0}}, 1'b1};
            default: w_count_next = r_count;
        endcase
    end

    // Register array, pending bits and count; synchronous active-low reset dominates.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            if (w_wr_valid) begin
                r_regs[ctrl_writeReg] <= data_writeReg;
            end
            r_pending <= w_pending_next;
            r_count   <= w_count_next;
        end
    end

    // Read ports, observation port and busy flags, with optional write forwarding.
    always_comb begin
        w_read_a   = (ctrl_readRegA == '0) ? '0 : r_regs[ctrl_readRegA];
        w_read_b   = (ctrl_readRegB == '0) ? '0 : r_regs[ctrl_readRegB];
        w_read_obs = (OBS_IDX == '0) ? '0 : r_regs[OBS_IDX];
        w_busy_a   = r_pending[ctrl_readRegA];
        w_busy_b   = r_pending[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_valid && (ctrl_writeReg == ctrl_readRegA)) begin
            w_read_a = data_writeReg;
            w_busy_a = 1'b0;
        end
        if (w_wr_valid && (ctrl_writeReg == ctrl_readRegB)) begin
            w_read_b = data_writeReg;
            w_busy_b = 1'b0;
        end
        if (w_wr_valid && (ctrl_writeReg == OBS_IDX)) begin
            w_read_obs = data_writeReg;
        end
`else
        // Stored contents only; a write becomes visible after its edge.
        w_read_obs = w_read_obs;
`endif
    end

    assign data_readRegA   = w_read_a;
    assign data_readRegB   = w_read_b;
    assign output_register = w_read_obs;
    assign busy_A          = w_busy_a;
    assign busy_B          = w_busy_b;
    assign pending_count   = r_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        ctrl_markPending;
    logic [4:0]  ctrl_pendingReg;
    logic        busy_A;
    logic        busy_B;
    logic [5:0]  pending_count;
    logic [31:0] output_register;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_scoreboard dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .ctrl_markPending (ctrl_markPending),
        .ctrl_pendingReg  (ctrl_pendingReg),
        .busy_A           (busy_A),
        .busy_B           (busy_B),
        .pending_count    (pending_count),
        .output_register  (output_register)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        mk;
        logic [4:0]  pr;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        ba;
        logic        bb;
        logic [5:0]  ec;
        logic [31:0] eo;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mkv(logic rst_n, logic we, logic [4:0] wr, logic [31:0] wd,
                                 logic mk, logic [4:0] pr, logic [4:0] ra, logic [4:0] rb,
                                 logic [31:0] ea, logic [31:0] eb, logic ba, logic bb,
                                 logic [5:0] ec, logic [31:0] eo);
        vec_t v;
        v.rst_n = rst_n; v.we = we; v.wr = wr; v.wd = wd; v.mk = mk; v.pr = pr;
        v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.ba = ba; v.bb = bb;
        v.ec = ec; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of strobes, clock it, then drop strobes and settle.
    task automatic apply(input logic rst_n, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic mk, input logic [4:0] pr,
                         input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clock);
        ctrl_reset       = rst_n;
        ctrl_writeEnable = we;
        ctrl_writeReg    = wr;
        data_writeReg    = wd;
        ctrl_markPending = mk;
        ctrl_pendingReg  = pr;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        @(posedge clock);
        #1;
        ctrl_reset       = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_markPending = 1'b0;
        #1;
    endtask

    initial begin
        ctrl_reset = 1'b1; ctrl_writeEnable = 1'b0; ctrl_writeReg = '0;
        data_writeReg = '0; ctrl_markPending = 1'b0; ctrl_pendingReg = '0;
        ctrl_readRegA = '0; ctrl_readRegB = '0;

        //              rst we wr  wdata         mk pr  ra  rb   expA          expB          bA bB cnt eo
        vecs[0]  = mkv(0, 0, 0,  32'h0,        0, 0,  5,  25,  32'h0,        32'h0,        0, 0, 0, 32'h0);
        vecs[1]  = mkv(1, 1, 5,  32'hDEADBEEF, 0, 0,  5,  0,   32'hDEADBEEF, 32'h0,        0, 0, 0, 32'h0);
        vecs[2]  = mkv(1, 1, 0,  32'hFFFFFFFF, 1, 0,  0,  5,   32'h0,        32'hDEADBEEF, 0, 0, 0, 32'h0);
        vecs[3]  = mkv(1, 0, 0,  32'h0,        1, 3,  3,  7,   32'h0,        32'h0,        1, 0, 1, 32'h0);
        vecs[4]  = mkv(1, 0, 0,  32'h0,        1, 7,  3,  7,   32'h0,        32'h0,        1, 1, 2, 32'h0);
        vecs[5]  = mkv(1, 1, 3,  32'h33,       0, 0,  3,  7,   32'h33,       32'h0,        0, 1, 1, 32'h0);
        vecs[6]  = mkv(1, 1, 7,  32'h77,       0, 0,  7,  3,   32'h77,       32'h33,       0, 0, 0, 32'h0);
        vecs[7]  = mkv(1, 1, 9,  32'h12,       1, 9,  9,  5,   32'h12,       32'hDEADBEEF, 1, 0, 1, 32'h0);
        vecs[8]  = mkv(1, 1, 9,  32'h99,       1, 10, 9,  10,  32'h99,       32'h0,        0, 1, 1, 32'h0);
        vecs[9]  = mkv(1, 1, 5,  32'h55,       0, 0,  5,  10,  32'h55,       32'h0,        0, 1, 1, 32'h0);
        vecs[10] = mkv(1, 0, 0,  32'h0,        1, 10, 10, 5,   32'h0,        32'h55,       1, 0, 1, 32'h0);
        vecs[11] = mkv(1, 1, 25, 32'hA5A5A5A5, 0, 0,  25, 10,  32'hA5A5A5A5, 32'h0,        0, 1, 1, 32'hA5A5A5A5);
        vecs[12] = mkv(1, 0, 0,  32'h0,        1, 1,  1,  10,  32'h0,        32'h0,        1, 1, 2, 32'hA5A5A5A5);
        vecs[13] = mkv(1, 0, 0,  32'h0,        1, 2,  2,  1,   32'h0,        32'h0,        1, 1, 3, 32'hA5A5A5A5);
        vecs[14] = mkv(1, 0, 0,  32'h0,        1, 3,  3,  4,   32'h33,       32'h0,        1, 0, 4, 32'hA5A5A5A5);
        vecs[15] = mkv(1, 0, 0,  32'h0,        1, 4,  4,  3,   32'h0,        32'h33,       1, 1, 5, 32'hA5A5A5A5);
        vecs[16] = mkv(0, 1, 2,  32'h22,       1, 3,  2,  5,   32'h0,        32'h0,        0, 0, 0, 32'h0);

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i].rst_n, vecs[i].we, vecs[i].wr, vecs[i].wd,
                  vecs[i].mk, vecs[i].pr, vecs[i].ra, vecs[i].rb);
            chk($sformatf("v%0d readA", i), data_readRegA, vecs[i].ea);
            chk($sformatf("v%0d readB", i), data_readRegB, vecs[i].eb);
            chk($sformatf("v%0d busyA", i), {31'b0, busy_A}, {31'b0, vecs[i].ba});
            chk($sformatf("v%0d busyB", i), {31'b0, busy_B}, {31'b0, vecs[i].bb});
            chk($sformatf("v%0d count", i), {26'b0, pending_count}, {26'b0, vecs[i].ec});
            chk($sformatf("v%0d obs", i), output_register, vecs[i].eo);
        end

        // Fill the scoreboard: the count tops out at 31 and a re-mark does not move it.
        for (int r = 1; r < 32; r++) begin
            apply(1, 0, 0, 32'h0, 1, 5'(r), 5'(r), 0);
        end
        chk("sat count", {26'b0, pending_count}, 32'd31);
        chk("sat busyA r31", {31'b0, busy_A}, 32'd1);
        apply(1, 0, 0, 32'h0, 1, 31, 31, 0);
        chk("sat remark", {26'b0, pending_count}, 32'd31);
        apply(1, 1, 1, 32'h1, 0, 0, 1, 0);
        chk("sat clear", {26'b0, pending_count}, 32'd30);
        chk("sat clear busy", {31'b0, busy_A}, 32'd0);

        // Same-cycle write to a pending observed register.
        apply(0, 0, 0, 32'h0, 0, 0, 0, 0);
        chk("rst count", {26'b0, pending_count}, 32'd0);
        apply(1, 1, 25, 32'hA5A5A5A5, 0, 0, 25, 25);
        apply(1, 0, 0, 32'h0, 1, 25, 25, 25);
        chk("pre busyA", {31'b0, busy_A}, 32'd1);
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd25;
        data_writeReg    = 32'h5A5A5A5A;
        ctrl_readRegA    = 5'd25;
        ctrl_readRegB    = 5'd0;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp readA", data_readRegA, 32'h5A5A5A5A);
        chk("byp obs", output_register, 32'h5A5A5A5A);
        chk("byp busyA", {31'b0, busy_A}, 32'd0);
`else
        chk("byp readA", data_readRegA, 32'hA5A5A5A5);
        chk("byp obs", output_register, 32'hA5A5A5A5);
        chk("byp busyA", {31'b0, busy_A}, 32'd1);
`endif
        chk("byp readB r0", data_readRegB, 32'h0);
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
        #1;
        chk("post readA", data_readRegA, 32'h5A5A5A5A);
        chk("post obs", output_register, 32'h5A5A5A5A);
        chk("post busyA", {31'b0, busy_A}, 32'd0);
        chk("post count", {26'b0, pending_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
